// File: rtl/cla_wide_add_sequencer_if.sv
// Request/response bundle between the ALU control (master) and the wide-add sequencer (slave).
interface cla_wide_add_sequencer_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_sub;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;

   modport master (
      output req_valid, op_a, op_b, op_sub, resp_ready,
      input  req_ready, resp_valid, result, carry_out, overflow
   );

   modport slave (
      input  req_valid, op_a, op_b, op_sub, resp_ready,
      output req_ready, resp_valid, result, carry_out, overflow
   );
endinterface

// File: rtl/cla_wide_add_sequencer.sv
// Runs a WIDTH-bit add/subtract through one shared combinational 16-bit CLA,
// one slice per cycle from the least-significant end, carry chained in a register.
module cla_wide_add_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   cla_wide_add_sequencer_if.slave bus,
   output logic [15:0]             adder_a,
   output logic [15:0]             adder_b,
   output logic                    adder_cin,
   input  logic [15:0]             adder_s,
   input  logic                    adder_cout
);
   localparam int unsigned NSLICE = WIDTH / 16;
   localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
   logic             cout_q, cout_d, ovf_q, ovf_d;
   logic             live_q;
   logic             accept, last;
   logic [15:0]      a_slice, b_slice;

   assign accept        = bus.req_valid && bus.req_ready;
   assign last          = (idx_q == LastIdx);
   assign bus.result    = result_q;
   assign bus.carry_out = cout_q;
   assign bus.overflow  = ovf_q;

   always_comb begin
      a_slice = '0;
      b_slice = '0;
      for (int unsigned i = 0; i < NSLICE; i++) begin
         if (idx_q == IdxW'(i)) begin
            a_slice = a_q[i*16 +: 16];
            b_slice = b_q[i*16 +: 16];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StRun;
         StRun:   if (last) state_d = StDone;
         StDone:  if (bus.resp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Adder inputs are forced to zero outside RUN so the shared CLA never sees stale operands.
   always_comb begin
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      adder_a        = '0;
      adder_b        = '0;
      adder_cin      = 1'b0;
      unique case (state_q)
         StIdle: bus.req_ready = live_q;
         StRun: begin
            adder_a   = a_slice;
            adder_b   = b_slice;
            adder_cin = carry_q;
         end
         StDone:  bus.resp_valid = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      if (accept) begin
         a_d      = bus.op_a;
         b_d      = bus.op_b ^ {WIDTH{bus.op_sub}};
         carry_d  = bus.op_sub;
         idx_d    = '0;
         result_d = '0;
      end else if (state_q == StRun) begin
         for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx_q == IdxW'(i)) result_d[i*16 +: 16] = adder_s;
         end
         carry_d = adder_cout;
         idx_d   = last ? '0 : idx_q + 1'b1;
         if (last) begin
            cout_d = adder_cout;
            ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (adder_s[15] != a_q[WIDTH-1]);
         end
      end
   end

   // live_q keeps req_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         live_q   <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         live_q   <= 1'b1;
      end
   end
endmodule
